// File: rtl/alu16_pkg.sv
// alu16_pkg: shared definitions for the 16-bit MIPS ALU.
//   ALU_W       datapath width
//   ALU_*       3-bit operation codes driven on aluOp
//   MUL_ITERS   number of shift-add iterations of the sequential multiplier
//   mul_state_t state encoding of the multiplier FSM
package alu16_pkg;

  localparam int ALU_W     = 16;
  localparam int MUL_ITERS = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_MUL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mult16_seq.sv
// mult16_seq: sequential shift-add multiplier, low 16 bits of an unsigned
// 16x16 product, one iteration per clock.
//   clk      system clock
//   reset    synchronous active-high; returns to idle and clears all state
//   start    multiply request level; begins a multiply while idle and must
//            stay high for the multiply to continue and the product to be held
//   a, b     operands, sampled only on the idle-to-busy edge
//   product  accumulated product (final once done is high)
//   busy     iterations in progress
//   done     product valid and held
module mult16_seq
  import alu16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] product,
  output logic             busy,
  output logic             done
);

  mul_state_t       state;
  logic [ALU_W-1:0] mcand;
  logic [ALU_W-1:0] mplier;
  logic [ALU_W-1:0] acc;
  logic [4:0]       cnt;

  // Only the low 16 bits of the product are kept, so the multiplicand can
  // shift out of a 16-bit register without losing anything that matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state  <= MUL_BUSY;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL_BUSY: begin
          if (!start) begin
            state <= MUL_IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'(MUL_ITERS - 1)) state <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (!start) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign product = acc;
  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);

endmodule

// File: rtl/alu16.sv
// alu16: 16-bit integer ALU for the single-cycle MIPS datapath.
//   clk, reset  system clock and synchronous active-high reset
//   a, b        operands; b is also the shift source
//   aluOp       operation select (ALU_* codes)
//   shamt       shift amount 0..15
//   result      operation result; 0 while a multiply is not yet done
//   zero        result == 0
//   ready       result is valid for the current aluOp
// All ops except MUL are combinational; MUL uses mult16_seq and raises
// ready after 17 consecutive edges with aluOp == MUL and reset low.
module alu16
  import alu16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       aluOp,
  input  logic [3:0]       shamt,
  output logic [ALU_W-1:0] result,
  output logic             zero,
  output logic             ready
);

  logic                    op_mul;
  logic                    mul_start;
  logic                    mul_busy;
  logic                    mul_done;
  logic                    mul_valid;
  logic [ALU_W-1:0]        mul_product;
  logic signed [ALU_W-1:0] a_s;
  logic signed [ALU_W-1:0] b_s;

  assign op_mul = (aluOp == ALU_MUL);
  assign a_s    = a;
  assign b_s    = b;

  // The multiplier only treats start as a start while idle; holding it high
  // afterwards keeps the multiply alive, dropping it aborts or releases.
  assign mul_start = op_mul;

  mult16_seq u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .product (mul_product),
    .busy    (mul_busy),
    .done    (mul_done)
  );

  assign mul_valid = mul_done & ~mul_busy;

  always_comb begin
    result = '0;
    case (aluOp)
      ALU_ADD: result = a + b;
      ALU_MUL: result = mul_valid ? mul_product : '0;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = (a_s < b_s) ? 16'd1 : 16'd0;
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign ready = op_mul ? mul_valid : 1'b1;
  assign zero  = (result == '0);

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: self-checking bench for alu16 with directed cases and random
// stimulus against a behavioural model that tracks consecutive MUL edges.
module tb_alu16;
  import alu16_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  aluOp;
  logic [3:0]  shamt;
  logic [15:0] result;
  logic        zero;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;

  // Model: number of consecutive edges with aluOp == MUL and reset low,
  // and the operands seen on the first of those edges.
  int          m_cnt = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;

  logic [15:0] lits [6] = '{16'hFEE6, 16'h0001, 16'h0127, 16'h0001, 16'd1156, 16'd72};

  always #5 clk = ~clk;

  alu16 dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .aluOp  (aluOp),
    .shamt  (shamt),
    .result (result),
    .zero   (zero),
    .ready  (ready)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (op=%0d a=0x%04h b=0x%04h sh=%0d)",
               tag, got, exp, aluOp, a, b, shamt);
    end
  endtask

  function automatic logic [15:0] ref_comb(input logic [2:0] op, input logic [15:0] x,
                                           input logic [15:0] y, input logic [3:0] sh);
    longint ux, uy, sx, sy, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    case (op)
      ALU_ADD: v = (ux + uy) % 65536;
      ALU_SUB: v = (ux + 65536 - uy) % 65536;
      ALU_AND: v = longint'(x & y);
      ALU_OR:  v = longint'(x | y);
      ALU_SLT: v = (sx < sy) ? 1 : 0;
      ALU_SLL: v = (uy * (longint'(1) << sh)) % 65536;
      ALU_SRL: v = uy / (longint'(1) << sh);
      default: v = (ux * uy) % 65536;
    endcase
    return v[15:0];
  endfunction

  task automatic apply(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] sh, input logic r, input string tag);
    logic [15:0] exp_res;
    logic        exp_rdy;
    aluOp = op; a = x; b = y; shamt = sh; reset = r;
    #1;
    if (op == ALU_MUL) begin
      exp_rdy = (m_cnt >= 17);
      exp_res = exp_rdy ? ref_comb(ALU_MUL, m_a, m_b, 4'd0) : 16'h0000;
    end else begin
      exp_rdy = 1'b1;
      exp_res = ref_comb(op, x, y, sh);
    end
    check({tag, "_result"}, result, exp_res);
    check({tag, "_ready"}, {15'b0, ready}, {15'b0, exp_rdy});
    check({tag, "_zero"}, {15'b0, zero}, {15'b0, (exp_res == 16'h0000)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_cnt = 0;
    else if (aluOp == ALU_MUL) begin
      if (m_cnt == 0) begin
        m_a = a;
        m_b = b;
      end
      if (m_cnt < 1000) m_cnt++;
    end else m_cnt = 0;
    @(negedge clk);
  endtask

  task automatic step(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic [3:0] sh, input logic r, input string tag);
    apply(op, x, y, sh, r, tag);
    tick();
  endtask

  // Full multiply from idle: 17 edges of latency, then a known product.
  task automatic mul_check(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] expv, input string tag);
    repeat (17) step(ALU_MUL, x, y, 4'd0, 1'b0, tag);
    apply(ALU_MUL, x, y, 4'd0, 1'b0, tag);
    check({tag, "_lit"}, result, expv);
    tick();
    step(ALU_ADD, x, y, 4'd0, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; aluOp = ALU_MUL; a = 16'd7; b = 16'd289; shamt = 4'd2;
    @(negedge clk);

    // Reset held with MUL requested, then released.
    repeat (3) step(ALU_MUL, 16'd7, 16'd289, 4'd2, 1'b1, "rst_mul");
    repeat (17) step(ALU_MUL, 16'd7, 16'd289, 4'd2, 1'b0, "mul_lat");
    apply(ALU_MUL, 16'd7, 16'd289, 4'd2, 1'b0, "mul_done");
    check("mul_7x289", result, 16'd2023);
    check("mul_7x289_ready", {15'b0, ready}, 16'd1);
    tick();
    repeat (2) step(ALU_MUL, 16'd7, 16'd289, 4'd2, 1'b0, "mul_hold");

    for (int i = 2; i < 8; i++) begin
      apply(3'(i), 16'd7, 16'd289, 4'd2, 1'b0, "ops");
      check("ops_lit", result, lits[i-2]);
      tick();
    end

    mul_check(16'd73, 16'd19, 16'd1387, "mul_73x19");
    mul_check(16'd40, 16'd52, 16'd2080, "mul_40x52");
    apply(ALU_SLT, 16'd40, 16'd52, 4'd0, 1'b0, "slt");
    check("slt_40_52", result, 16'd1);
    tick();
    apply(ALU_SUB, 16'd40, 16'd52, 4'd0, 1'b0, "sub");
    check("sub_40_52", result, 16'hFFF4);
    tick();

    apply(ALU_SUB, 16'd40, 16'd40, 4'd0, 1'b0, "sub_eq");
    check("sub_eq_zero", {15'b0, zero}, 16'd1);
    tick();
    apply(ALU_SLT, 16'd40, 16'd40, 4'd0, 1'b0, "slt_eq");
    check("slt_eq_zero", {15'b0, zero}, 16'd1);
    tick();
    mul_check(16'd40, 16'd40, 16'd1600, "mul_40x40");

    // Reset at iteration 8, release with MUL held.
    repeat (9) step(ALU_MUL, 16'd300, 16'd5, 4'd0, 1'b0, "abort_rst");
    step(ALU_MUL, 16'd300, 16'd5, 4'd0, 1'b1, "abort_rst");
    mul_check(16'd300, 16'd5, 16'd1500, "mul_after_rst");

    // Leave MUL mid-multiply.
    repeat (6) step(ALU_MUL, 16'd100, 16'd3, 4'd0, 1'b0, "abort_op");
    apply(ALU_ADD, 16'd100, 16'd3, 4'd0, 1'b0, "abort_add");
    check("abort_add_lit", result, 16'd103);
    tick();
    mul_check(16'd100, 16'd3, 16'd300, "mul_after_abort");

    apply(ALU_SLT, 16'h8000, 16'd1, 4'd0, 1'b0, "slt_neg");
    check("slt_neg_lit", result, 16'd1);
    tick();
    apply(ALU_SLL, 16'h0000, 16'hFFFF, 4'd15, 1'b0, "sll15");
    check("sll15_lit", result, 16'h8000);
    tick();
    apply(ALU_SRL, 16'h0000, 16'hABCD, 4'd0, 1'b0, "srl0");
    check("srl0_lit", result, 16'hABCD);
    tick();
    mul_check(16'hFFFF, 16'hFFFF, 16'h0001, "mul_ffff");

    // Random mix; operands change freely during multiplies.
    for (int it = 0; it < 300; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == ALU_MUL) op = ALU_ADD;
        step(op, 16'($urandom), 16'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0), "rnd_comb");
      end else begin
        int len;
        len = int'($urandom_range(1, 22));
        for (int k = 0; k < len; k++) begin
          step(ALU_MUL, 16'($urandom), 16'($urandom), 4'($urandom),
               ($urandom_range(0, 39) == 0), "rnd_mul");
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu16.md
# alu16

16-bit integer ALU for the single-cycle MIPS datapath. Add, subtract, logic, set-less-than and shift complete combinationally. Multiply runs on an internal sequential shift-add unit that takes several cycles. `ready` tells the control path when `result` is valid.

## Interface
Parameters:
- none. Width is fixed at 16.

Ports:
- `clk`  in  1  system clock; one clock domain, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `a`  in  16  operand A.
- `b`  in  16  operand B; also the shift source.
- `aluOp`  in  3  operation select.
- `shamt`  in  4  shift amount, 0–15.
- `result`  out  16  operation result.
- `zero`  out  1  high when `result == 16'h0000`.
- `ready`  out  1  high when `result` is valid for the current `aluOp`.

## Operation
Opcodes:
- 000 ADD: a + b, mod 2^16.
- 001 MUL: low 16 bits of a × b, unsigned, multi-cycle.
- 010 SUB: a − b, mod 2^16.
- 011 AND: a & b.
- 100 OR: a | b.
- 101 SLT: 16'd1 if $signed(a) < $signed(b), else 0.
- 110 SLL: b << shamt.
- 111 SRL: b >> shamt, logical (zero fill).

Combinational ops:
- Every op except MUL is purely combinational from `a`, `b`, `shamt`.
- For these ops `ready` = 1, independent of `reset`.

`zero`:
- Always combinational: `zero` = (`result` == 0).

No overflow or carry outputs.

MUL state machine (IDLE, BUSY, DONE):
- IDLE → BUSY: on an edge where `aluOp` == 001 and `reset` = 0. Latch A into the multiplicand, B into the multiplier, clear the accumulator and the 5-bit counter.
- BUSY: each edge adds multiplicand to the accumulator if multiplier[0] = 1, then shifts multiplicand left 1 and multiplier right 1, and increments the counter. After 16 iterations → DONE.
- DONE: hold the product. Return to IDLE on any edge where `aluOp` ≠ 001.
- BUSY → IDLE: if `aluOp` leaves 001 during BUSY, abort on that edge.
- Operands are sampled only on IDLE → BUSY. Changing `a`/`b` in BUSY or DONE has no effect until the next start.

MUL outputs:
- In IDLE or BUSY: `ready` = 0, `result` = 0, so `zero` = 1.
- In DONE: `ready` = 1, `result` = product.

Reset:
- `reset` = 1 forces IDLE and clears the accumulator, operand registers and counter.
- Takes priority over a start or iteration on the same edge.
- Reset mid-multiply aborts it.
- A MUL held across the reset release starts on the first edge with `reset` = 0.

## Timing
- Combinational ops: zero-cycle latency.
- MUL latency:
  - Edge 1 (start): IDLE → BUSY.
  - Edges 2–17: the 16 iterations; edge 17 enters DONE.
  - `ready` rises after the 17th edge with `aluOp` = 001 and `reset` = 0.
- `ready` and `result` stay stable in DONE while `aluOp` is held at 001.
- Back-to-back MUL requires `aluOp` to leave 001 for at least one edge.

## Structure
- `alu16_pkg`: opcode localparams (`ALU_ADD` … `ALU_SRL`), the MUL FSM state enum, `ALU_W` = 16.
- One sub-module, `mult16_seq`:
  - Ports: clk, reset, start, a, b, product, busy, done.
  - Holds the FSM and datapath.
- The top level `alu16` holds:
  - the combinational op mux;
  - the `ready`/`zero` logic;
  - start = (`aluOp` == 001) while idle.

## Test plan
- a=7, b=289, shamt=2, reset held, then released with aluOp=001 → `ready` low for 17 edges, then `result`=2023, `ready`=1, `zero`=0.
- Same operands, ops 010..111 → 0xFEE6, 0x0001, 0x0127, 1, 1156, 72; `ready`=1 throughout.
- a=73, b=19 MUL → 1387. a=40, b=52 MUL → 2080, then SLT → 1 and SUB → 0xFFF4.
- a=40, b=40 → SUB gives 0 with `zero`=1 and SLT gives 0 with `zero`=1; MUL gives 1600.
- Abort cases:
  - Assert `reset` at iteration 8 of a MUL, release with aluOp=001 → fresh full 17-edge latency and the correct product.
  - Switch aluOp to ADD mid-multiply → ADD result immediately, MUL state returns to IDLE.
- Signed SLT and shift edges:
  - a=0x8000, b=1, SLT → 1.
  - SLL b=0xFFFF, shamt=15 → 0x8000.
  - SRL shamt=0 → b unchanged.
  - MUL 0xFFFF × 0xFFFF → 0x0001.
